// File: rtl/cache_pkg.sv
// Shared cache-hierarchy definitions: data path width and the LSU operation
// encoding carried from the cache controllers down to the DRAM model.
package cache_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        LSU_LOAD  = 2'd0,
        LSU_STORE = 2'd1
    } lsu_ops;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and the DRAM
// port. The slave modport is the arbiter's view; master is the environment's.
//
// Handshake rules:
//   rN_req is a level held by the requester until it sees rN_rsp_valid.
//   rN_rsp_valid is a one-cycle completion pulse.
//   mem_req stays high, with mem_addr/op/wdata stable, until mem_ready pulses.
//   mem_rdata is only meaningful in the cycle mem_ready is high.
interface dram_port_arbiter_if #(
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
);
    logic                  r0_req;
    logic [ADDR_WIDTH-1:0] r0_addr;
    cache_pkg::lsu_ops     r0_op;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_rsp_valid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic [ADDR_WIDTH-1:0] r1_addr;
    cache_pkg::lsu_ops     r1_op;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_rsp_valid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    cache_pkg::lsu_ops     mem_op;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  arb_owner;
    logic                  timeout_err;
    // Arbiter FSM state for observation (0 IDLE, 1 BUSY, 2 RESP).
    logic [1:0]            dbg_state;

    modport slave (
        input  r0_req, r0_addr, r0_op, r0_wdata,
        input  r1_req, r1_addr, r1_op, r1_wdata,
        input  mem_ready, mem_rdata,
        output r0_rsp_valid, r0_rdata, r1_rsp_valid, r1_rdata,
        output mem_req, mem_addr, mem_op, mem_wdata,
        output arb_owner, timeout_err, dbg_state
    );

    modport master (
        output r0_req, r0_addr, r0_op, r0_wdata,
        output r1_req, r1_addr, r1_op, r1_wdata,
        output mem_ready, mem_rdata,
        input  r0_rsp_valid, r0_rdata, r1_rsp_valid, r1_rdata,
        input  mem_req, mem_addr, mem_op, mem_wdata,
        input  arb_owner, timeout_err, dbg_state
    );

endinterface

// File: rtl/dram_port_arbiter.sv
// Two-requester round-robin arbiter in front of the single DRAM port.
// The winning request is latched onto mem_*, held until mem_ready, and the
// read data is returned to the owner with a one-cycle rsp_valid pulse.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT_CYCLES cycles without mem_ready.
module dram_port_arbiter #(
    parameter int DATA_WIDTH     = cache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_last_owner;
    logic                  r_owner;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    cache_pkg::lsu_ops     r_mem_op;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rsp_valid0;
    logic                  r_rsp_valid1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_grant;
    logic                  w_winner;
    logic                  w_complete;
    logic                  w_timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]      r_to_cnt;
    logic                  r_timeout_err;

    // The watchdog fires in the last allowed BUSY cycle; a mem_ready in that
    // same cycle wins and the transaction completes normally.
    assign w_timeout = (r_state == ST_BUSY) && !bus.mem_ready &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared at grant, counts every BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_grant) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    // Registered one-cycle error pulse, aligned with the owner's rsp_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and arbitration decision; on a tie the non-last owner wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_winner    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                    if (bus.r0_req && bus.r1_req) begin
                        w_winner = ~r_last_owner;
                    end else begin
                        w_winner = bus.r1_req;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, response capture and round-robin history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_op     <= cache_pkg::LSU_LOAD;
            r_mem_wdata  <= '0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_owner      <= 1'b1;
            r_last_owner <= 1'b1;
        end else begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;

            if (w_grant) begin
                r_mem_req   <= 1'b1;
                r_owner     <= w_winner;
                r_mem_addr  <= w_winner ? bus.r1_addr  : bus.r0_addr;
                r_mem_op    <= w_winner ? bus.r1_op    : bus.r0_op;
                r_mem_wdata <= w_winner ? bus.r1_wdata : bus.r0_wdata;
            end

            if (w_complete) begin
                r_mem_req <= 1'b0;
                if (r_owner) begin
                    r_rsp_valid1 <= 1'b1;
                    r_rdata1     <= bus.mem_rdata;
                end else begin
                    r_rsp_valid0 <= 1'b1;
                    r_rdata0     <= bus.mem_rdata;
                end
            end

            // Aborted transaction: respond immediately with zero data and
            // skip the RESP state, so history is updated here.
            if (w_timeout) begin
                r_mem_req    <= 1'b0;
                r_last_owner <= r_owner;
                if (r_owner) begin
                    r_rsp_valid1 <= 1'b1;
                    r_rdata1     <= '0;
                end else begin
                    r_rsp_valid0 <= 1'b1;
                    r_rdata0     <= '0;
                end
            end

            if (r_state == ST_RESP) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_op       = r_mem_op;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.r0_rsp_valid = r_rsp_valid0;
    assign bus.r1_rsp_valid = r_rsp_valid1;
    assign bus.r0_rdata     = r_rdata0;
    assign bus.r1_rdata     = r_rdata1;
    assign bus.arb_owner    = r_owner;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter. Expected grants and responses are
// queued as tokens when stimulus is issued; a monitor pops and compares them
// whenever mem_req rises or an rsp_valid pulses. Define ARB_TIMEOUT_EN to
// include the watchdog scenarios (TIMEOUT_CYCLES = 8).
module tb_dram_port_arbiter;

  localparam int DW = cache_pkg::DATA_WIDTH;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  dram_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Token: [34] kind (0 grant, 1 response), [33] requester, [32] timeout, [31:0] addr/data
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [63:0] tok(input logic kind, input logic who,
                                      input logic to, input logic [31:0] d);
    return {29'd0, kind, who, to, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%s: got %h expected nothing", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  // Monitor: compare every grant and response against the expected queue.
  initial begin
    logic        prev_req;
    logic [31:0] held_addr;
    prev_req  = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        held_addr = bus.mem_addr;
        pop_cmp("grant", tok(1'b0, bus.arb_owner, 1'b0, bus.mem_addr));
      end else if (bus.mem_req && prev_req) begin
        chk("mem_addr_hold", {32'd0, bus.mem_addr}, {32'd0, held_addr});
      end
      if (bus.r0_rsp_valid && bus.r1_rsp_valid) begin
        chk("rsp_both", 64'd1, 64'd0);
      end else if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
        pop_cmp("response", tok(1'b1, bus.r1_rsp_valid, bus.timeout_err,
                                bus.r1_rsp_valid ? bus.r1_rdata : bus.r0_rdata));
      end else if (bus.timeout_err) begin
        chk("stray_timeout", 64'd1, 64'd0);
      end
      prev_req = bus.mem_req;
    end
  end

  // DRAM driver: wait for mem_req, let `waits` more cycles pass, pulse mem_ready.
  // Returns on the negedge where the response pulse is visible.
  task automatic dram_serve(input logic [31:0] data, input int waits);
    int t;
    t = 0;
    while (!bus.mem_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("dram_wait_bound", 64'd1, 64'd0);
    repeat (waits) @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rd[4];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33; rd[3] = 32'h44;

    bus.r0_req = 1'b0; bus.r0_addr = '0; bus.r0_op = cache_pkg::LSU_LOAD; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_addr = '0; bus.r1_op = cache_pkg::LSU_LOAD; bus.r1_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req",   {63'd0, bus.mem_req}, 64'd0);
    chk("rst_mem_addr",  {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_op",    {62'd0, bus.mem_op}, {62'd0, cache_pkg::LSU_LOAD});
    chk("rst_arb_owner", {63'd0, bus.arb_owner}, 64'd1);
    chk("rst_rsp",       {62'd0, bus.r0_rsp_valid, bus.r1_rsp_valid}, 64'd0);
    chk("rst_rdata",     {bus.r0_rdata, bus.r1_rdata}, 64'd0);
    chk("rst_timeout",   {63'd0, bus.timeout_err}, 64'd0);
    chk("rst_state",     {62'd0, bus.dbg_state}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester 0 read
    bus.r0_addr = 32'h100; bus.r0_wdata = 32'hA5;
    exp_q.push_back(tok(1'b0, 1'b0, 1'b0, 32'h100));
    exp_q.push_back(tok(1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
    bus.r0_req = 1'b1;
    @(negedge clk);
    chk("latency_mem_req", {63'd0, bus.mem_req}, 64'd1);
    chk("latency_addr", {32'd0, bus.mem_addr}, 64'h100);
    dram_serve(32'hDEADBEEF, 2);
    chk("t1_r0_rdata", {32'd0, bus.r0_rdata}, 64'hDEADBEEF);
    bus.r0_req = 1'b0;

    // Both requesters from reset: strict alternation 0,1,0,1
    reset_pulse();
    bus.r0_addr = 32'h200;
    bus.r1_addr = 32'h300; bus.r1_op = cache_pkg::LSU_STORE; bus.r1_wdata = 32'hCAFE;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tok(1'b0, 1'(i % 2), 1'b0, (i % 2) ? 32'h300 : 32'h200));
      exp_q.push_back(tok(1'b1, 1'(i % 2), 1'b0, rd[i]));
    end
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dram_serve(rd[i], i);
      chk("rr_arb_owner", {63'd0, bus.arb_owner}, 64'(i % 2));
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    chk("rr_r0_rdata_hold", {32'd0, bus.r0_rdata}, 64'h33);
    chk("rr_r1_rdata", {32'd0, bus.r1_rdata}, 64'h44);

    // Requester 1 pulses one cycle; address changes during BUSY
    @(negedge clk);
    bus.r1_addr = 32'h400; bus.r1_wdata = 32'h1234;
    exp_q.push_back(tok(1'b0, 1'b1, 1'b0, 32'h400));
    exp_q.push_back(tok(1'b1, 1'b1, 1'b0, 32'h55));
    bus.r1_req = 1'b1;
    @(negedge clk);
    bus.r1_req = 1'b0; bus.r1_addr = 32'h4FC; bus.r1_wdata = 32'h9999;
    chk("t3_mem_op", {62'd0, bus.mem_op}, {62'd0, cache_pkg::LSU_STORE});
    chk("t3_mem_wdata", {32'd0, bus.mem_wdata}, 64'h1234);
    dram_serve(32'h55, 3);
    chk("t3_r1_rdata", {32'd0, bus.r1_rdata}, 64'h55);

    // mem_ready while IDLE is ignored
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("idle_ready_state", {62'd0, bus.dbg_state}, 64'd0);
    chk("idle_ready_req", {63'd0, bus.mem_req}, 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_ready_rdata", {bus.r0_rdata, bus.r1_rdata}, {32'h33, 32'h55});

    // Reset mid-BUSY
    bus.r0_addr = 32'h500;
    exp_q.push_back(tok(1'b0, 1'b0, 1'b0, 32'h500));
    bus.r0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("async_rst_state", {62'd0, bus.dbg_state}, 64'd0);
    bus.r0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_rdata", {bus.r0_rdata, bus.r1_rdata}, 64'd0);
    chk("post_rst_owner", {63'd0, bus.arb_owner}, 64'd1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: DRAM silent for requester 0, then requester 1 completes on cycle 8
    begin
      int t;
      int busy;
      bus.r0_addr = 32'h600; bus.r1_addr = 32'h700;
      exp_q.push_back(tok(1'b0, 1'b0, 1'b0, 32'h600));
      exp_q.push_back(tok(1'b1, 1'b0, 1'b1, 32'h0));
      exp_q.push_back(tok(1'b0, 1'b1, 1'b0, 32'h700));
      exp_q.push_back(tok(1'b1, 1'b1, 1'b0, 32'h77));
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      t = 0; busy = 0;
      do begin
        @(negedge clk);
        if (bus.mem_req) busy++;
        t++;
      end while (!bus.r0_rsp_valid && t < 40);
      chk("to_busy_cycles", 64'(busy), 64'(TO));
      chk("to_err_pulse", {63'd0, bus.timeout_err}, 64'd1);
      bus.r0_req = 1'b0;
      dram_serve(32'h77, TO - 1);
      chk("to_edge_no_err", {63'd0, bus.timeout_err}, 64'd0);
      bus.r1_req = 1'b0;
    end
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single dummy_dram port between two cache controllers (e.g. instruction-side and data-side) in the cache hierarchy.
- Sits between the controllers' mem_req/mem_ready handshakes and the DRAM.
- Latches the winning request, holds the DRAM request until mem_ready, then returns read data and a one-cycle response pulse to the owner.

Parameters:
DATA_WIDTH, cache_pkg::DATA_WIDTH, width of write/read data paths
ADDR_WIDTH, 32, width of request address
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
r0_req  input  1  requester 0 request, level, held until r0_rsp_valid
r0_addr  input  ADDR_WIDTH  requester 0 address
r0_op  input  cache_pkg::lsu_ops  requester 0 operation, forwarded unchanged
r0_wdata  input  DATA_WIDTH  requester 0 write data
r0_rsp_valid  output  1  one-cycle completion pulse to requester 0
r0_rdata  output  DATA_WIDTH  read data to requester 0
r1_req, r1_addr, r1_op, r1_wdata, r1_rsp_valid, r1_rdata  (same directions and widths as r0_*, for requester 1)
mem_req  output  1  request to DRAM
mem_addr  output  ADDR_WIDTH  latched address to DRAM
mem_op  output  cache_pkg::lsu_ops  latched operation to DRAM
mem_wdata  output  DATA_WIDTH  latched write data to DRAM
mem_ready  input  1  DRAM completion, one-cycle pulse
mem_rdata  input  DATA_WIDTH  DRAM read data, valid with mem_ready
arb_owner  output  1  index of the current or most recent owner
timeout_err  output  1  one-cycle watchdog pulse; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - Force state to IDLE.
  - Clear mem_req, mem_addr, mem_wdata, r0/r1_rsp_valid, r0/r1_rdata, and timeout_err to 0.
  - Set mem_op to its first enum value.
  - Set last_owner to 1, so requester 0 wins the first tie; arb_owner resets to 1.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, select the winner and move to BUSY next edge.
  - Latch the winner's addr/op/wdata into mem_* and assert mem_req on the same edge.
  - Latency: req high in cycle N gives mem_req high in cycle N+1.
- Selection:
  - Only one requester high: it wins.
  - Both high: the requester != last_owner wins.
  - Neither high: stay in IDLE.
- BUSY:
  - Hold mem_req=1 and mem_addr/op/wdata stable regardless of requester inputs.
  - On mem_ready=1: capture mem_rdata into the owner's rdata, go to RESP, drop mem_req.
- RESP (one cycle):
  - Owner's rsp_valid=1; the other requester's rsp_valid stays 0.
  - last_owner updates to the owner.
  - Next edge returns to IDLE.
  - Next grant earliest 2 cycles after the mem_ready cycle, so there are no back-to-back mem_req without one low cycle.
- rdata holds its value until that requester's next completion. Write ops also capture mem_rdata; the captured value is don't-care to requesters.
- mem_ready in IDLE or RESP is ignored.
- Requester deasserting req while BUSY: the transaction completes normally and rsp_valid still pulses.
- Fairness: both requesters continuously high strictly alternate grants (0,1,0,1...).
- arb_owner updates at grant and holds through IDLE.
- Reset asserted mid-BUSY: mem_req drops immediately (async) and the transaction is discarded without a response.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter clears at grant and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ready:
    - drop mem_req;
    - pulse timeout_err for one cycle;
    - pulse the owner's rsp_valid in the same cycle with rdata = 0;
    - update last_owner;
    - return to IDLE.
  - mem_ready arriving in the same cycle the counter hits the limit counts as success; no error is raised.
- Not defined: no counter exists, BUSY waits indefinitely, and timeout_err is constant 0.

Test Plan:
- Reset then r0_req=1 alone, addr=0x100 → mem_req=1 next cycle, mem_addr=0x100. DRAM pulses mem_ready with rdata=0xDEADBEEF → r0_rsp_valid pulse next cycle, r0_rdata=0xDEADBEEF, r1_rsp_valid stays 0.
- r0_req and r1_req both high from reset for 4 transactions → grant order 0,1,0,1; arb_owner follows. Each mem_req separated by at least one low cycle.
- r1_req pulses high one cycle then drops while BUSY → transaction completes and r1_rsp_valid still pulses. mem_addr stays stable while r1_addr changes during BUSY.
- mem_ready pulsed while IDLE with no requests → no rsp_valid and no state change. Assert rst low mid-BUSY → mem_req=0 asynchronously; after release, no stale rsp_valid.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, DRAM never responds → after 8 BUSY cycles, timeout_err pulses once, owner rsp_valid pulses with rdata=0, and the pending other requester is granted next.
- With ARB_TIMEOUT_EN, mem_ready arrives exactly on cycle 8 → normal completion with timeout_err=0.
